io_arbiter: RTL and testbench

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_arbiter.sv | 165 ++++++++++++++++
 tb/tb_io_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// io_arbiter: merges a CPU output strobe and a debug valid/ready stream through per-source FIFOs
// into one registered output, round-robin on ties. Define IO_ARB_DROP_COUNT_EN for drop_count.

module io_arbiter_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end
endmodule

module io_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_data,
    input  logic             dbg_valid,
    input  logic [WIDTH-1:0] dbg_data,
    output logic             dbg_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             cpu_full,
    output logic             cpu_drop
`ifdef IO_ARB_DROP_COUNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);
    logic             cpu_push;
    logic             cpu_pop;
    logic             cpu_empty;
    logic [WIDTH-1:0] cpu_head;
    logic             dbg_push;
    logic             dbg_pop;
    logic             dbg_full;
    logic             dbg_empty;
    logic [WIDTH-1:0] dbg_head;
    logic             last_grant;
    logic             out_free;
    logic             grant_any;
    logic             grant_dbg;
    logic             drop;

    // A full CPU FIFO drops the strobe even if the same edge pops it.
    assign drop      = cpu_wr & cpu_full;
    assign cpu_push  = cpu_wr & ~cpu_full & ~rst;
    assign dbg_ready = ~dbg_full;
    assign dbg_push  = dbg_valid & ~dbg_full & ~rst;
    assign out_free  = ~out_valid | out_ready;

    always_comb begin
        grant_any = 1'b0;
        grant_dbg = 1'b0;
        if (out_free) begin
            if (!cpu_empty && !dbg_empty) begin
                grant_any = 1'b1;
                grant_dbg = ~last_grant;
            end else if (!cpu_empty) begin
                grant_any = 1'b1;
            end else if (!dbg_empty) begin
                grant_any = 1'b1;
                grant_dbg = 1'b1;
            end
        end
    end

    assign cpu_pop = grant_any & ~grant_dbg & ~rst;
    assign dbg_pop = grant_any & grant_dbg & ~rst;

    io_arbiter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_cpu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_push),
        .push_data (cpu_data),
        .pop       (cpu_pop),
        .full      (cpu_full),
        .empty     (cpu_empty),
        .head      (cpu_head)
    );

    io_arbiter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dbg_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dbg_push),
        .push_data (dbg_data),
        .pop       (dbg_pop),
        .full      (dbg_full),
        .empty     (dbg_empty),
        .head      (dbg_head)
    );

    // last_grant resets to debug so the CPU takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            cpu_drop   <= 1'b0;
        end else begin
            cpu_drop <= drop;
            if (out_free) begin
                out_valid <= grant_any;
                if (grant_any) begin
                    out_data   <= grant_dbg ? dbg_head : cpu_head;
                    out_src    <= grant_dbg;
                    last_grant <= grant_dbg;
                end
            end
        end
    end

`ifdef IO_ARB_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: queue-based reference model with a per-cycle compare process,
// plus directed scenarios with literal expectations.

module tb_io_arbiter;
    localparam int W = 64;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_wr = 1'b0;
    logic [W-1:0] cpu_data = '0;
    logic         dbg_valid = 1'b0;
    logic [W-1:0] dbg_data = '0;
    logic         out_ready = 1'b0;
    logic         dbg_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         cpu_full;
    logic         cpu_drop;
`ifdef IO_ARB_DROP_COUNT_EN
    logic [15:0]  drop_count;
`endif

    io_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_wr    (cpu_wr),
        .cpu_data  (cpu_data),
        .dbg_valid (dbg_valid),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .cpu_full  (cpu_full),
        .cpu_drop  (cpu_drop)
`ifdef IO_ARB_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: two queues, one output slot, a last-grant bit.
    logic [W-1:0] cq[$];
    logic [W-1:0] dq[$];
    logic [W:0]   log_q[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_src = 1'b0;
    logic         m_lg = 1'b1;
    logic         m_drop = 1'b0;
    int           m_dcnt = 0;

    always @(posedge clk) begin
        bit cf;
        bit df;
        bit take;
        bit src;
        if (rst) begin
            cq.delete();
            dq.delete();
            log_q.delete();
            m_valid = 1'b0;
            m_data = '0;
            m_src = 1'b0;
            m_lg = 1'b1;
            m_drop = 1'b0;
            m_dcnt = 0;
        end else begin
            cf = (cq.size() == D);
            df = (dq.size() == D);
            src = 1'b0;
            take = 1'b0;
            if (m_valid && out_ready) log_q.push_back({m_src, m_data});
            if (!m_valid || out_ready) begin
                if (cq.size() > 0 && dq.size() > 0) begin
                    take = 1'b1;
                    src = !m_lg;
                end else if (cq.size() > 0) begin
                    take = 1'b1;
                end else if (dq.size() > 0) begin
                    take = 1'b1;
                    src = 1'b1;
                end
                if (take) begin
                    m_data = src ? dq.pop_front() : cq.pop_front();
                    m_src = src;
                    m_lg = src;
                end
                m_valid = take;
            end
            m_drop = cpu_wr && cf;
            if (m_drop && m_dcnt < 65535) m_dcnt++;
            if (cpu_wr && !cf) cq.push_back(cpu_data);
            if (dbg_valid && !df) dq.push_back(dbg_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_valid);
            check("out_data", out_data, m_data);
            check("out_src", out_src, m_src);
            check("cpu_full", cpu_full, cq.size() == D);
            check("dbg_ready", dbg_ready, dq.size() != D);
            check("cpu_drop", cpu_drop, m_drop);
`ifdef IO_ARB_DROP_COUNT_EN
            check("drop_count", drop_count, m_dcnt[15:0]);
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_wr = 1'b0;
        dbg_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    function automatic logic [64:0] log_at(input int k);
        return (k < log_q.size()) ? log_q[k] : {1'b1, {W{1'b1}}};
    endfunction

    logic [64:0] exp35 [6];
    bit acc;
    bit vld;
    int idx;

    initial begin
        // reset state
        do_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_src", out_src, 1'b0);
        check("rst_cpu_drop", cpu_drop, 1'b0);
        check("rst_cpu_full", cpu_full, 1'b0);
        check("rst_dbg_ready", dbg_ready, 1'b1);

        // single CPU word, two-edge latency
        out_ready = 1'b1;
        cpu_wr = 1'b1;
        cpu_data = 64'h1234;
        cyc();
        cpu_wr = 1'b0;
        check("lat_n_valid", out_valid, 1'b0);
        cyc();
        check("lat_n1_valid", out_valid, 1'b1);
        check("lat_n1_data", out_data, 64'h1234);
        check("lat_n1_src", out_src, 1'b0);
        cyc();
        check("lat_after_valid", out_valid, 1'b0);

        // tie after reset alternates, CPU first
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_wr = 1'b1;
            cpu_data = 64'hA0 + 64'(k);
            dbg_valid = 1'b1;
            dbg_data = 64'hB0 + 64'(k);
            cyc();
        end
        cpu_wr = 1'b0;
        dbg_valid = 1'b0;
        repeat (8) cyc();
        exp35 = '{{1'b0, 64'hA0}, {1'b1, 64'hB0}, {1'b0, 64'hA1},
                  {1'b1, 64'hB1}, {1'b0, 64'hA2}, {1'b1, 64'hB2}};
        check("rr_count", log_q.size(), 6);
        for (int k = 0; k < 6; k++) check("rr_order", log_at(k), exp35[k]);

        // CPU overflow with a stalled sink
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cpu_wr = 1'b1;
            cpu_data = 64'(k);
            cyc();
            if (k == 5) begin
                check("ovf_full5", cpu_full, 1'b1);
                check("ovf_drop5", cpu_drop, 1'b0);
            end
        end
        cpu_wr = 1'b0;
        check("ovf_drop6", cpu_drop, 1'b1);
        check("ovf_full6", cpu_full, 1'b1);
        check("ovf_head", out_data, 64'h1);
`ifdef IO_ARB_DROP_COUNT_EN
        check("ovf_dcnt", drop_count, 16'd1);
`endif
        cyc();
        check("ovf_drop_end", cpu_drop, 1'b0);
        out_ready = 1'b1;
        repeat (8) cyc();
        check("ovf_count", log_q.size(), 5);
        for (int k = 0; k < 5; k++) check("ovf_order", log_at(k), {1'b0, 64'(k + 1)});

        // debug backpressure
        do_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            dbg_valid = 1'b1;
            dbg_data = 64'hD0 + 64'(idx);
            acc = dbg_ready;
            cyc();
            if (acc) idx++;
            if (i >= 1) begin
                check("bp_valid", out_valid, 1'b1);
                check("bp_hold", out_data, 64'hD0);
            end
            if (i == 3) check("bp_ready3", dbg_ready, 1'b1);
            if (i == 4) check("bp_ready4", dbg_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vld = (idx < 8);
            dbg_valid = vld;
            dbg_data = 64'hD0 + 64'(idx);
            acc = dbg_ready;
            cyc();
            if (acc && vld) idx++;
        end
        dbg_valid = 1'b0;
        repeat (10) cyc();
        check("bp_count", log_q.size(), 8);
        for (int k = 0; k < 8; k++) check("bp_order", log_at(k), {1'b1, 64'hD0 + 64'(k)});

        // reset while both FIFOs and the output hold words
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cpu_wr = 1'b1;
            cpu_data = 64'hE0 + 64'(k);
            dbg_valid = 1'b1;
            dbg_data = 64'hF0 + 64'(k);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cpu_wr = 1'b0;
        dbg_valid = 1'b0;
        check("mr_valid", out_valid, 1'b0);
        check("mr_full", cpu_full, 1'b0);
        check("mr_ready", dbg_ready, 1'b1);
        out_ready = 1'b1;
        repeat (8) cyc();
        check("mr_stale", log_q.size(), 0);
        check("mr_valid_end", out_valid, 1'b0);

        // mixed traffic with intermittent sink stalls
        for (int i = 0; i < 60; i++) begin
            cpu_wr = (i % 3) != 1;
            cpu_data = 64'h1000 + 64'(i);
            dbg_valid = (i % 4) != 3;
            dbg_data = 64'h2000 + 64'(i);
            out_ready = (i % 5) < 3;
            cyc();
        end
        cpu_wr = 1'b0;
        dbg_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) cyc();
        check("mix_drained", out_valid, 1'b0);

`ifdef IO_ARB_DROP_COUNT_EN
        // drop counter saturation
        do_reset();
        out_ready = 1'b0;
        cpu_wr = 1'b1;
        cpu_data = 64'h55;
        repeat (65545) cyc();
        cpu_wr = 1'b0;
        check("sat_dcnt", drop_count, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
